// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - flushable elastic pipeline stage with optional skid entry and sticky halt
// Carries an opaque payload between two pipeline stages using a valid/ready handshake.
module pipe_stage_elastic #(
  parameter int unsigned       DATA_W    = 96,
  parameter int unsigned       SKID      = 1,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_halt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_halt,
  output logic [1:0]        count
);

  logic              head_halt;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic              skid_halt;
  logic              halt_pending;
  logic              halt_done;
  logic              blocked;
  logic              accept;
  logic              consume;

  // With a skid entry, in_ready depends only on registered state.
  always_comb begin
    blocked = halt_pending | halt_done;
    if (SKID != 0) begin
      in_ready = !skid_valid && !blocked;
    end else begin
      in_ready = (!out_valid || out_ready) && !blocked;
    end
  end

  assign accept   = in_valid && in_ready;
  assign consume  = out_valid && out_ready;
  assign count    = {1'b0, out_valid} + {1'b0, skid_valid};
  assign out_halt = (out_valid && head_halt) || halt_done;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      out_valid    <= 1'b0;
      out_data     <= RESET_VAL;
      head_halt    <= 1'b0;
      skid_valid   <= 1'b0;
      skid_data    <= RESET_VAL;
      skid_halt    <= 1'b0;
      halt_pending <= 1'b0;
      halt_done    <= 1'b0;
    end else begin
      // A halt head retiring in a flush cycle still retires.
      if (consume && head_halt) begin
        halt_done    <= 1'b1;
        halt_pending <= 1'b0;
      end else if (accept && in_halt) begin
        halt_pending <= 1'b1;
      end

      if (flush) begin
        out_valid    <= 1'b0;
        out_data     <= RESET_VAL;
        head_halt    <= 1'b0;
        skid_valid   <= 1'b0;
        skid_data    <= RESET_VAL;
        skid_halt    <= 1'b0;
        halt_pending <= 1'b0;
      end else if ((SKID != 0) && skid_valid) begin
        // Skid full means in_ready is low, so only a consume can move entries.
        if (consume) begin
          out_data   <= skid_data;
          head_halt  <= skid_halt;
          skid_valid <= 1'b0;
        end
      end else if (accept && (consume || !out_valid)) begin
        out_valid <= 1'b1;
        out_data  <= in_data;
        head_halt <= in_halt;
      end else if (accept) begin
        skid_valid <= 1'b1;
        skid_data  <= in_data;
        skid_halt  <= in_halt;
      end else if (consume) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb/tb_pipe_stage_elastic.sv - scoreboard bench for pipe_stage_elastic, skid and no-skid variants
// Both variants see identical stimulus; each has its own FIFO reference model.
module tb_pipe_stage_elastic;

  localparam logic [31:0] RV0 = 32'h1357_2468;
  localparam logic [31:0] RV1 = 32'hDEAD_BEEF;

  logic        CLK;
  logic        nRST;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_halt;
  logic        out_ready;

  logic        ir0, ov0, oh0, ir1, ov1, oh1;
  logic [31:0] od0, od1;
  logic [1:0]  cnt0, cnt1;

  int tests = 0;
  int fails = 0;

  // Reference model: up to two queued entries per variant plus halt flags.
  int          size    [2];
  logic [31:0] ent_d   [2][2];
  logic        ent_h   [2][2];
  logic        pend    [2];
  logic        done    [2];
  logic        rflag   [2];
  logic        started [2];

  pipe_stage_elastic #(.DATA_W(32), .SKID(1), .RESET_VAL(RV0)) dut_skid (
    .CLK(CLK), .nRST(nRST), .flush(flush),
    .in_valid(in_valid), .in_ready(ir0), .in_data(in_data), .in_halt(in_halt),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_halt(oh0),
    .count(cnt0)
  );

  pipe_stage_elastic #(.DATA_W(32), .SKID(0), .RESET_VAL(RV1)) dut_noskid (
    .CLK(CLK), .nRST(nRST), .flush(flush),
    .in_valid(in_valid), .in_ready(ir1), .in_data(in_data), .in_halt(in_halt),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_halt(oh1),
    .count(cnt1)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s inst%0d: got %0h expected %0h", nm, k, act, exp);
    end
  endtask

  // Compares the DUT against the model, then advances the model through the coming edge.
  task automatic step(input int k, input bit skid, input logic [31:0] rv,
                      input logic dir, input logic dov, input logic [31:0] dod,
                      input logic doh, input logic [1:0] dcnt);
    logic exp_ready;
    logic cons;
    logic popped_h;
    exp_ready = !pend[k] && !done[k] && (skid ? (size[k] < 2) : (size[k] == 0 || out_ready));
    if (started[k]) begin
      chk("count", k, 64'(dcnt), 64'(size[k]));
      chk("out_valid", k, 64'(dov), 64'(size[k] > 0));
      chk("in_ready", k, 64'(dir), 64'(exp_ready));
      chk("out_halt", k, 64'(doh), 64'((size[k] > 0 && ent_h[k][0]) || done[k]));
      if (size[k] > 0) chk("out_data", k, 64'(dod), 64'(ent_d[k][0]));
      else if (rflag[k]) chk("reset_data", k, 64'(dod), 64'(rv));
    end
    cons = (size[k] > 0) && out_ready;
    if (!nRST) begin
      size[k] = 0; pend[k] = 0; done[k] = 0; rflag[k] = 1; started[k] = 1;
    end else if (started[k]) begin
      if (cons) begin
        popped_h = ent_h[k][0];
        ent_d[k][0] = ent_d[k][1];
        ent_h[k][0] = ent_h[k][1];
        size[k]--;
        if (popped_h) begin done[k] = 1; pend[k] = 0; end
      end
      if (flush) begin
        size[k] = 0; pend[k] = 0; rflag[k] = 1;
      end else if (in_valid && exp_ready) begin
        ent_d[k][size[k]] = in_data;
        ent_h[k][size[k]] = in_halt;
        size[k]++;
        if (in_halt) pend[k] = 1;
        rflag[k] = 0;
      end
    end
  endtask

  always @(negedge CLK) begin
    step(0, 1'b1, RV0, ir0, ov0, od0, oh0, cnt0);
    step(1, 1'b0, RV1, ir1, ov1, od1, oh1, cnt1);
  end

  task automatic drive(input logic r, input logic v, input logic [31:0] d,
                       input logic h, input logic f, input logic o);
    nRST = r; in_valid = v; in_data = d; in_halt = h; flush = f; out_ready = o;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      size[k] = 0; pend[k] = 0; done[k] = 0; rflag[k] = 0; started[k] = 0;
      ent_d[k][0] = '0; ent_d[k][1] = '0; ent_h[k][0] = 0; ent_h[k][1] = 0;
    end
    // Reset with in_valid asserted.
    drive(0, 1, 32'h99, 0, 0, 1);
    drive(0, 1, 32'h99, 0, 0, 1);
    // Streaming.
    for (int i = 1; i <= 8; i++) drive(1, 1, 32'(i), 0, 0, 1);
    drive(1, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 1);
    // Back-pressure.
    drive(1, 1, 32'hA, 0, 0, 0);
    drive(1, 1, 32'hB, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 1);
    // Flush with full stage and an incoming entry.
    drive(1, 1, 32'hA, 0, 0, 0);
    drive(1, 1, 32'hB, 0, 0, 0);
    drive(1, 1, 32'hC, 0, 1, 0);
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 1);
    // Halt: sticky across consume and flush, cleared only by reset.
    drive(1, 1, 32'h5, 1, 0, 0);
    drive(1, 1, 32'h6, 0, 0, 0);
    drive(1, 1, 32'h6, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 1);
    drive(1, 1, 32'h7, 0, 0, 1);
    drive(1, 1, 32'h7, 0, 0, 1);
    drive(1, 0, 0, 0, 1, 1);
    drive(1, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 1);
    // Randomised traffic with occasional halt, flush and reset.
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 60) != 0, $urandom_range(0, 3) != 0, $urandom,
            $urandom_range(0, 24) == 0, $urandom_range(0, 30) == 0,
            $urandom_range(0, 2) != 0);
    end
    drive(1, 0, 0, 0, 0, 1);
    @(negedge CLK);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
